// File: rtl/video_pkg.sv
// Shared definitions for the palette/DAC video output stage: component width,
// ordered-dither threshold table, fade FSM encoding and per-component helpers.
package video_pkg;

    localparam int COMP_W = 5;

    // Bit-reversed 3-bit phase: spreads the thresholds evenly across phases.
    localparam logic [2:0] DITHER_T [0:7] = '{
        3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7
    };

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_WAIT = 2'd1,
        FADE_STEP = 2'd2
    } fade_state_t;

    // (c * bright) >> 4; bright is 0..16, so 16 is the identity.
    function automatic logic [COMP_W-1:0] scale_comp(
        input logic [COMP_W-1:0] c,
        input logic [4:0]        b
    );
        return COMP_W'(({5'd0, c} * {5'd0, b}) >> 4);
    endfunction

    // Returns the coarse part of c, bumped by one when the fraction (scaled to
    // 3 bits) beats the threshold. The bump never wraps past all-ones.
    function automatic logic [COMP_W-1:0] dither_sat(
        input logic [COMP_W-1:0] c,
        input logic [2:0]        t,
        input int                frac_w
    );
        logic [COMP_W-1:0] coarse;
        logic [COMP_W-1:0] frac3;
        logic [COMP_W-1:0] top;
        coarse = c >> frac_w;
        frac3  = (c - (coarse << frac_w)) << (3 - frac_w);
        top    = COMP_W'((1 << (COMP_W - frac_w)) - 1);
        if ((frac3 > {2'b00, t}) && (coarse != top))
            return coarse + 5'd1;
        return coarse;
    endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: synchronous write, synchronous read returning the
// pre-write contents when both ports hit the same address on one edge.
module dpram #(
    parameter int    AW        = 8,
    parameter int    DW        = 16,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    (* ram_init_file = INIT_FILE *) logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/video_fade_ctrl.sv
// Per-frame brightness fade engine: steps bright toward a target once every
// (fade_rate+1) frames, and keeps the frame parity used by temporal dither.
module video_fade_ctrl
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [4:0] fade_target,
    input  logic [3:0] fade_rate,
    input  logic       fade_go,
    output logic [4:0] bright,
    output logic       fade_busy,
    output logic       frame_par
);

    fade_state_t state;
    logic [4:0]  target;
    logic [3:0]  cnt;
    logic [4:0]  go_target;
    logic [4:0]  eff_target;
    logic [4:0]  next_bright;

    // A retarget arriving in the STEP cycle steers that very step.
    always_comb begin
        go_target   = (fade_target > 5'd16) ? 5'd16 : fade_target;
        eff_target  = fade_go ? go_target : target;
        next_bright = bright;
        if (bright < eff_target)
            next_bright = bright + 5'd1;
        else if (bright > eff_target)
            next_bright = bright - 5'd1;
    end

    assign fade_busy = (state != FADE_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FADE_IDLE;
            target    <= 5'd16;
            cnt       <= 4'd0;
            bright    <= 5'd16;
            frame_par <= 1'b0;
        end else begin
            if (frame_start)
                frame_par <= ~frame_par;
            if (fade_go)
                target <= go_target;

            case (state)
                FADE_IDLE: begin
                    if (fade_go) begin
                        cnt <= fade_rate;
                        if (go_target != bright)
                            state <= FADE_WAIT;
                    end
                end
                FADE_WAIT: begin
                    // Retarget keeps the running frame count.
                    if (fade_go && (go_target == bright))
                        state <= FADE_IDLE;
                    else if (frame_start) begin
                        if (cnt == 4'd0)
                            state <= FADE_STEP;
                        else
                            cnt <= cnt - 4'd1;
                    end
                end
                FADE_STEP: begin
                    bright <= next_bright;
                    if (next_bright == eff_target)
                        state <= FADE_IDLE;
                    else begin
                        cnt   <= fade_rate;
                        state <= FADE_WAIT;
                    end
                end
                default: state <= FADE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/video_dac_dither.sv
// Palette lookup, brightness scale and ordered dither down to a DAC_W-bit DAC.
// Three-stage pipeline: RAM read register, scale register, dither/output register.
module video_dac_dither
    import video_pkg::*;
#(
    parameter int    DAC_W    = 2,
    parameter int    PAL_AW   = 8,
    parameter string PAL_INIT = "rtl/video/video_cram.mif"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAL_AW-1:0] pix_in,
    input  logic              blank_in,
    input  logic              line_odd,
    input  logic              frame_start,
    input  logic [PAL_AW-1:0] cram_addr_in,
    input  logic [15:0]       cram_data_in,
    input  logic              cram_we,
    input  logic [4:0]        fade_target,
    input  logic [3:0]        fade_rate,
    input  logic              fade_go,
    output logic [DAC_W-1:0]  vred,
    output logic [DAC_W-1:0]  vgrn,
    output logic [DAC_W-1:0]  vblu,
    output logic [4:0]        vred_raw,
    output logic [4:0]        vgrn_raw,
    output logic [4:0]        vblu_raw,
    output logic              vdac_mode,
    output logic              fade_busy,
    output logic [4:0]        bright
);

    localparam int FRAC_W = COMP_W - DAC_W;

    logic [15:0]       ram_q;
    logic              frame_par;
    logic              ph;
    logic              blank1;
    logic              blank2;
    logic [COMP_W-1:0] r_s;
    logic [COMP_W-1:0] g_s;
    logic [COMP_W-1:0] b_s;
    logic              mode_s;
    logic [2:0]        phase;
    logic [2:0]        thr;

    // Stage 1 lives inside the RAM (address/data register).
    dpram #(
        .AW        (PAL_AW),
        .DW        (16),
        .INIT_FILE (PAL_INIT)
    ) u_cram (
        .clk     (clk),
        .we      (cram_we),
        .wr_addr (cram_addr_in),
        .wr_data (cram_data_in),
        .rd_addr (pix_in),
        .rd_data (ram_q)
    );

    video_fade_ctrl u_fade (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .fade_target (fade_target),
        .fade_rate   (fade_rate),
        .fade_go     (fade_go),
        .bright      (bright),
        .fade_busy   (fade_busy),
        .frame_par   (frame_par)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank1 <= 1'b1;
            ph     <= 1'b0;
        end else begin
            blank1 <= blank_in;
            ph     <= ~ph;
        end
    end

    // Stage 2: scale by current brightness, zero during blanking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank2 <= 1'b1;
            r_s    <= '0;
            g_s    <= '0;
            b_s    <= '0;
            mode_s <= 1'b0;
        end else begin
            blank2 <= blank1;
            if (blank1) begin
                r_s    <= '0;
                g_s    <= '0;
                b_s    <= '0;
                mode_s <= 1'b0;
            end else begin
                r_s    <= scale_comp(ram_q[14:10], bright);
                g_s    <= scale_comp(ram_q[9:5], bright);
                b_s    <= scale_comp(ram_q[4:0], bright);
                mode_s <= ram_q[15];
            end
        end
    end

    always_comb begin
        phase = {frame_par, line_odd, ph};
        thr   = DITHER_T[phase];
    end

    // Stage 3: spatial+temporal ordered dither and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vred      <= '0;
            vgrn      <= '0;
            vblu      <= '0;
            vred_raw  <= '0;
            vgrn_raw  <= '0;
            vblu_raw  <= '0;
            vdac_mode <= 1'b0;
        end else if (blank2) begin
            vred      <= '0;
            vgrn      <= '0;
            vblu      <= '0;
            vred_raw  <= '0;
            vgrn_raw  <= '0;
            vblu_raw  <= '0;
            vdac_mode <= 1'b0;
        end else begin
            vred      <= DAC_W'(dither_sat(r_s, thr, FRAC_W));
            vgrn      <= DAC_W'(dither_sat(g_s, thr, FRAC_W));
            vblu      <= DAC_W'(dither_sat(b_s, thr, FRAC_W));
            vred_raw  <= r_s;
            vgrn_raw  <= g_s;
            vblu_raw  <= b_s;
            vdac_mode <= mode_s;
        end
    end

endmodule

// File: tb/tb_video_dac_dither.sv
// Directed bench for video_dac_dither (DAC_W=2) with an expected-value queue
// for the pixel pipeline and a small behavioural model of the fade engine.
module tb_video_dac_dither;
    import video_pkg::*;

    localparam int VW = 22;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic       blank_in = 1'b1;
    logic       line_odd = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] cram_addr_in = '0;
    logic [15:0] cram_data_in = '0;
    logic       cram_we = 1'b0;
    logic [4:0] fade_target = '0;
    logic [3:0] fade_rate = '0;
    logic       fade_go = 1'b0;
    logic [1:0] vred, vgrn, vblu;
    logic [4:0] vred_raw, vgrn_raw, vblu_raw;
    logic       vdac_mode, fade_busy;
    logic [4:0] bright;

    video_dac_dither #(
        .DAC_W    (2),
        .PAL_AW   (8),
        .PAL_INIT ("rtl/video/video_cram.mif")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_in       (pix_in),
        .blank_in     (blank_in),
        .line_odd     (line_odd),
        .frame_start  (frame_start),
        .cram_addr_in (cram_addr_in),
        .cram_data_in (cram_data_in),
        .cram_we      (cram_we),
        .fade_target  (fade_target),
        .fade_rate    (fade_rate),
        .fade_go      (fade_go),
        .vred         (vred),
        .vgrn         (vgrn),
        .vblu         (vblu),
        .vred_raw     (vred_raw),
        .vgrn_raw     (vgrn_raw),
        .vblu_raw     (vblu_raw),
        .vdac_mode    (vdac_mode),
        .fade_busy    (fade_busy),
        .bright       (bright)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [VW-1:0] exp_q[$];
    logic [15:0] mem_m [0:255];
    bit          m_ph = 1'b0;
    bit          m_frame = 1'b0;
    bit          push_flag = 1'b0;
    bit [2:0]    trk = '0;
    bit          cnt_en = 1'b0;
    int          hits = 0;
    int          m_bright = 16;
    int          m_tgt = 16;
    int          m_cnt = 0;
    int          m_rate = 0;
    bit          m_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] model(input logic [7:0] pix, input bit blank);
        logic [15:0] e;
        int p, t, c, cs, coarse, frac;
        logic [1:0] dq [3];
        logic [4:0] cq [3];
        if (blank)
            return '0;
        e = mem_m[pix];
        p = (m_frame ? 4 : 0) + (line_odd ? 2 : 0) + (m_ph ? 1 : 0);
        t = ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
        for (int i = 0; i < 3; i++) begin
            c      = int'(e[14 - 5*i -: 5]);
            cs     = (c * m_bright) / 16;
            coarse = cs / 8;
            frac   = cs % 8;
            cq[i]  = 5'(cs);
            dq[i]  = 2'((frac > t && coarse < 3) ? coarse + 1 : coarse);
        end
        return {dq[0], dq[1], dq[2], cq[0], cq[1], cq[2], e[15]};
    endfunction

    task automatic tick();
        logic [VW-1:0] obs, e;
        trk = {trk[1:0], push_flag};
        push_flag = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            m_ph = 1'b0;
            m_frame = 1'b0;
        end else begin
            m_ph = ~m_ph;
            if (frame_start)
                m_frame = ~m_frame;
            if (cram_we)
                mem_m[cram_addr_in] = cram_data_in;
        end
        if (trk[2]) begin
            obs = {vred, vgrn, vblu, vred_raw, vgrn_raw, vblu_raw, vdac_mode};
            e = exp_q.pop_front();
            check("pix", {10'd0, obs}, {10'd0, e});
            if (cnt_en && vred == 2'd2)
                hits++;
        end
    endtask

    task automatic drive(input logic [7:0] pix, input bit blank);
        pix_in = pix;
        blank_in = blank;
        exp_q.push_back(model(pix, blank));
        push_flag = 1'b1;
        tick();
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++)
            drive(8'h00, 1'b1);
    endtask

    task automatic cram_write(input logic [7:0] a, input logic [15:0] d);
        cram_addr_in = a;
        cram_data_in = d;
        cram_we = 1'b1;
        tick();
        cram_we = 1'b0;
    endtask

    task automatic m_go(input int t);
        m_tgt = (t > 16) ? 16 : t;
        if (!m_busy) begin
            m_cnt = m_rate;
            m_busy = (m_tgt != m_bright);
        end else if (m_tgt == m_bright) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic m_frame_ev();
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_bright += (m_tgt > m_bright) ? 1 : -1;
                if (m_bright == m_tgt)
                    m_busy = 1'b0;
                else
                    m_cnt = m_rate;
            end else begin
                m_cnt--;
            end
        end
    endtask

    task automatic go(input int t, input int r);
        fade_target = 5'(t);
        fade_rate = 4'(r);
        m_rate = r;
        fade_go = 1'b1;
        tick();
        fade_go = 1'b0;
        m_go(t);
        tick();
        check("go_busy", {31'd0, fade_busy}, {31'd0, m_busy});
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_frame_ev();
        tick();
        tick();
        check("bright", {27'd0, bright}, m_bright);
        check("busy", {31'd0, fade_busy}, {31'd0, m_busy});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        tick();
        check("rst_video", {10'd0, vred, vgrn, vblu, vred_raw, vgrn_raw, vblu_raw, vdac_mode}, 32'd0);
        check("rst_bright", {27'd0, bright}, 32'd16);
        check("rst_busy", {31'd0, fade_busy}, 32'd0);
        check("rst_state", {30'd0, dut.u_fade.state}, {30'd0, FADE_IDLE});
        rst = 1'b0;

        cram_write(8'h05, 16'h7FFF);
        cram_write(8'h06, 16'h3000);
        cram_write(8'h07, 16'hD547);
        cram_write(8'h10, 16'h0421);

        // White pixel: saturates at full scale on every phase
        for (int i = 0; i < 8; i++)
            drive(8'h05, 1'b0);
        flush();

        // R = 0b01100 across all 8 dither phases
        cnt_en = 1'b1;
        hits = 0;
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 2; l++) begin
                if (m_frame != f[0]) begin
                    frame_start = 1'b1;
                    tick();
                    frame_start = 1'b0;
                end
                line_odd = l[0];
                drive(8'h06, 1'b0);
                drive(8'h06, 1'b0);
                drive(8'h00, 1'b1);
                drive(8'h00, 1'b1);
            end
        end
        flush();
        cnt_en = 1'b0;
        check("dither_hits", hits, 32'd4);
        line_odd = 1'b0;

        // Read during write: old data this cycle, new data next cycle
        cram_addr_in = 8'h10;
        cram_data_in = 16'h1234;
        cram_we = 1'b1;
        drive(8'h10, 1'b0);
        cram_we = 1'b0;
        drive(8'h10, 1'b0);
        drive(8'h07, 1'b0);
        flush();

        // Five-cycle blank pulse over a white stream
        for (int i = 0; i < 12; i++)
            drive(8'h05, (i >= 3 && i < 8));
        flush();

        // Fade 16 -> 0 at one step per two frames, stopped at 10
        go(0, 1);
        for (int i = 0; i < 12; i++)
            frame_pulse();
        for (int i = 0; i < 4; i++)
            drive(8'h07, 1'b0);
        drive(8'h05, 1'b0);
        drive(8'h05, 1'b0);
        flush();

        // Retarget upward while waiting
        go(12, 1);
        for (int i = 0; i < 4; i++)
            frame_pulse();
        check("retarget_state", {30'd0, dut.u_fade.state}, {30'd0, FADE_IDLE});

        // Reset in the middle of a fade
        go(0, 1);
        for (int i = 0; i < 3; i++)
            frame_pulse();
        rst = 1'b1;
        trk = '0;
        m_bright = 16;
        m_busy = 1'b0;
        m_tgt = 16;
        tick();
        check("midrst_bright", {27'd0, bright}, 32'd16);
        check("midrst_busy", {31'd0, fade_busy}, 32'd0);
        check("midrst_video", {10'd0, vred, vgrn, vblu, vred_raw, vgrn_raw, vblu_raw, vdac_mode}, 32'd0);
        rst = 1'b0;

        // Full fade to black over 32 frames
        go(0, 1);
        for (int i = 0; i < 32; i++)
            frame_pulse();
        check("black_state", {30'd0, dut.u_fade.state}, {30'd0, FADE_IDLE});
        for (int i = 0; i < 4; i++)
            drive(8'h05, 1'b0);
        flush();

        // Target above 16 clamps; rate 0 steps every frame
        go(31, 0);
        for (int i = 0; i < 16; i++)
            frame_pulse();
        go(16, 0);
        for (int i = 0; i < 4; i++)
            drive(8'h06, 1'b0);
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
